// File: rtl/rs_pkg.sv
// rs_pkg: shared widths, tag constants and tag match helper for the reservation station slot
package rs_pkg;
    localparam int FIELD_W = 8;
    localparam int TAG_W = 4;
    localparam logic [TAG_W-1:0] TAG_NONE = 4'h0;
    function automatic logic tag_hit(input logic [TAG_W-1:0] tag, input logic [TAG_W-1:0] bus);
        return bus != TAG_NONE && bus == tag;
    endfunction
endpackage

// File: rtl/rs_src_snoop.sv
// rs_src_snoop: tracks one source operand's tag, ready bit and captured value
module rs_src_snoop
    import rs_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               valid,
    input  logic [TAG_W-1:0]   depid,
    input  logic [TAG_W-1:0]   depins,
    input  logic [FIELD_W-1:0] depinval,
    output logic               rdy,
    output logic [FIELD_W-1:0] val
);
    logic [TAG_W-1:0] tag;
    // load with same-cycle bypass, otherwise capture the first matching broadcast
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            tag <= TAG_NONE;
            rdy <= 1'b0;
            val <= '0;
        end else if (load) begin
            tag <= depid;
            rdy <= depid == TAG_NONE || tag_hit(depid, depins);
            val <= tag_hit(depid, depins) ? depinval : '0;
        end else if (valid && !rdy && tag_hit(tag, depins)) begin
            rdy <= 1'b1;
            val <= depinval;
        end
endmodule

// File: rtl/rs.sv
// rs: single-entry reservation station slot with dispatch token and FU claim chains
module rs
    import rs_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FIELD_W-1:0]      operandin,
    input  logic [FIELD_W-1:0]      wbsin,
    input  logic [FIELD_W-1:0]      flagin,
    input  logic [FIELD_W-1:0]      robidin,
    input  logic [1:0][TAG_W-1:0]   depidsin,
    input  logic                    camtransmit,
    input  logic [TAG_W-1:0]        depins,
    input  logic [FIELD_W-1:0]      depinval,
    input  logic                    fuclaimed,
    output logic [FIELD_W-1:0]      operandout,
    output logic [FIELD_W-1:0]      wbsout,
    output logic [FIELD_W-1:0]      flagout,
    output logic [FIELD_W-1:0]      robidout,
    output logic [1:0][FIELD_W-1:0] depvalsout,
    output logic                    futransmitout,
    output logic                    fuclaimedout,
    output logic                    camtransmitout
);
    logic       valid;
    logic       load;
    logic       ready;
    logic [1:0] rdy;
    assign load = camtransmit && !valid;
    assign ready = valid && &rdy;
    assign futransmitout = ready && !fuclaimed;
    assign fuclaimedout = fuclaimed || ready;
    assign camtransmitout = camtransmit && valid;
    // occupancy: cleared when the FU bus is taken, set when a token lands on a free slot
    always_ff @(posedge clk or posedge rst)
        if (rst) valid <= 1'b0;
        else if (futransmitout) valid <= 1'b0;
        else if (load) valid <= 1'b1;
    // stored fields stay on the outputs after release
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            operandout <= '0;
            wbsout <= '0;
            flagout <= '0;
            robidout <= '0;
        end else if (load) begin
            operandout <= operandin;
            wbsout <= wbsin;
            flagout <= flagin;
            robidout <= robidin;
        end
    for (genvar i = 0; i < 2; i++) begin : g_src
        rs_src_snoop u_src (
            .clk(clk),
            .rst(rst),
            .load(load),
            .valid(valid),
            .depid(depidsin[i]),
            .depins(depins),
            .depinval(depinval),
            .rdy(rdy[i]),
            .val(depvalsout[i])
        );
    end
endmodule

// File: tb/tb_rs.sv
// tb_rs: table-driven directed vectors plus randomized run against a behavioural slot model
module tb_rs;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] operandin, wbsin, flagin, robidin, depinval;
    logic [1:0][3:0] depidsin;
    logic camtransmit, fuclaimed;
    logic [3:0] depins;
    logic [7:0] operandout, wbsout, flagout, robidout;
    logic [1:0][7:0] depvalsout;
    logic futransmitout, fuclaimedout, camtransmitout;
    int checks = 0;
    int failures = 0;

    rs dut (
        .clk(clk), .rst(rst),
        .operandin(operandin), .wbsin(wbsin), .flagin(flagin), .robidin(robidin),
        .depidsin(depidsin), .camtransmit(camtransmit), .depins(depins),
        .depinval(depinval), .fuclaimed(fuclaimed),
        .operandout(operandout), .wbsout(wbsout), .flagout(flagout), .robidout(robidout),
        .depvalsout(depvalsout), .futransmitout(futransmitout),
        .fuclaimedout(fuclaimedout), .camtransmitout(camtransmitout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic cam, fc;
        logic [7:0] op, wb, fl, rob;
        logic [3:0] d1, d0, dins;
        logic [7:0] dval;
        logic ft, fco, cto;
        logic [7:0] eop, ewb, efl, erob, ev1, ev0;
        logic [1:0] vm;
    } vec_t;
    vec_t tbl[18];

    // behavioural model of the slot contents
    logic mv;
    logic [7:0] mf[4];
    logic [3:0] mt[2];
    logic mr[2];
    logic [7:0] mval[2];

    task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, a, e);
        end
    endtask

    task automatic drive(input logic cam, input logic fc, input logic [7:0] op, input logic [7:0] wb,
                         input logic [7:0] fl, input logic [7:0] rob, input logic [3:0] d1,
                         input logic [3:0] d0, input logic [3:0] dins, input logic [7:0] dval);
        camtransmit = cam; fuclaimed = fc;
        operandin = op; wbsin = wb; flagin = fl; robidin = rob;
        depidsin[1] = d1; depidsin[0] = d0; depins = dins; depinval = dval;
    endtask

    task automatic model_reset();
        mv = 0;
        for (int k = 0; k < 4; k++) mf[k] = 0;
        for (int k = 0; k < 2; k++) begin mt[k] = 0; mr[k] = 0; mval[k] = 0; end
    endtask

    task automatic model_edge();
        logic issue;
        issue = mv && mr[0] && mr[1] && !fuclaimed;
        if (issue) mv = 0;
        else if (!mv && camtransmit) begin
            mv = 1;
            mf[0] = operandin; mf[1] = wbsin; mf[2] = flagin; mf[3] = robidin;
            for (int k = 0; k < 2; k++) begin
                mt[k] = depidsin[k];
                mr[k] = depidsin[k] == 0 || depidsin[k] == depins;
                mval[k] = (depidsin[k] != 0 && depidsin[k] == depins) ? depinval : 8'h00;
            end
        end else if (mv && depins != 0)
            for (int k = 0; k < 2; k++)
                if (!mr[k] && mt[k] == depins) begin mr[k] = 1; mval[k] = depinval; end
    endtask

    task automatic model_check();
        logic rdy_all;
        rdy_all = mv && mr[0] && mr[1];
        chk("r_ft", {7'b0, futransmitout}, {7'b0, rdy_all && !fuclaimed});
        chk("r_fco", {7'b0, fuclaimedout}, {7'b0, rdy_all || fuclaimed});
        chk("r_cto", {7'b0, camtransmitout}, {7'b0, camtransmit && mv});
        chk("r_op", operandout, mf[0]);
        chk("r_wb", wbsout, mf[1]);
        chk("r_fl", flagout, mf[2]);
        chk("r_rob", robidout, mf[3]);
        for (int k = 0; k < 2; k++)
            if (mr[k]) chk($sformatf("r_val%0d", k), depvalsout[k], mval[k]);
    endtask

    initial begin
        tbl[0]  = '{1'b1,1'b0,8'hAA,8'hBB,8'h10,8'h01,4'd7,4'd3,4'd0,8'h00, 1'b0,1'b0,1'b0, 8'h00,8'h00,8'h00,8'h00, 8'h00,8'h00, 2'b11};
        tbl[1]  = '{1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd3,8'hC3, 1'b0,1'b0,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'h00,8'h00, 2'b00};
        tbl[2]  = '{1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd5,8'hFF, 1'b0,1'b0,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'h00,8'hC3, 2'b01};
        tbl[3]  = '{1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd7,8'hD7, 1'b0,1'b0,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'h00,8'hC3, 2'b01};
        tbl[4]  = '{1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd0,8'h00, 1'b1,1'b1,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'hD7,8'hC3, 2'b11};
        tbl[5]  = '{1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd0,8'h00, 1'b0,1'b0,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'hD7,8'hC3, 2'b11};
        tbl[6]  = '{1'b1,1'b1,8'hAA,8'hBB,8'h10,8'h01,4'd7,4'd3,4'd0,8'h00, 1'b0,1'b1,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'hD7,8'hC3, 2'b11};
        tbl[7]  = '{1'b0,1'b1,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd3,8'hC3, 1'b0,1'b1,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'h00,8'h00, 2'b00};
        tbl[8]  = '{1'b0,1'b1,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd7,8'hD7, 1'b0,1'b1,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'h00,8'hC3, 2'b01};
        tbl[9]  = '{1'b0,1'b1,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd0,8'h00, 1'b0,1'b1,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'hD7,8'hC3, 2'b11};
        tbl[10] = '{1'b1,1'b1,8'h11,8'h22,8'h33,8'h44,4'd2,4'd1,4'd0,8'h00, 1'b0,1'b1,1'b1, 8'hAA,8'hBB,8'h10,8'h01, 8'hD7,8'hC3, 2'b11};
        tbl[11] = '{1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd0,8'h00, 1'b1,1'b1,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'hD7,8'hC3, 2'b11};
        tbl[12] = '{1'b1,1'b0,8'h5A,8'h6B,8'h7C,8'h8D,4'd0,4'd0,4'd0,8'h00, 1'b0,1'b0,1'b0, 8'hAA,8'hBB,8'h10,8'h01, 8'hD7,8'hC3, 2'b11};
        tbl[13] = '{1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd0,8'h00, 1'b1,1'b1,1'b0, 8'h5A,8'h6B,8'h7C,8'h8D, 8'h00,8'h00, 2'b11};
        tbl[14] = '{1'b1,1'b0,8'h01,8'h02,8'h03,8'h04,4'd4,4'd4,4'd4,8'h9C, 1'b0,1'b0,1'b0, 8'h5A,8'h6B,8'h7C,8'h8D, 8'h00,8'h00, 2'b11};
        tbl[15] = '{1'b1,1'b0,8'hEE,8'hEE,8'hEE,8'hEE,4'd0,4'd0,4'd0,8'h00, 1'b1,1'b1,1'b1, 8'h01,8'h02,8'h03,8'h04, 8'h9C,8'h9C, 2'b11};
        tbl[16] = '{1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd0,8'h00, 1'b0,1'b0,1'b0, 8'h01,8'h02,8'h03,8'h04, 8'h9C,8'h9C, 2'b11};
        tbl[17] = '{1'b0,1'b0,8'h00,8'h00,8'h00,8'h00,4'd0,4'd0,4'd0,8'h00, 1'b0,1'b0,1'b0, 8'h01,8'h02,8'h03,8'h04, 8'h9C,8'h9C, 2'b11};

        rst = 1;
        drive(1, 0, 8'h12, 8'h34, 8'h56, 8'h78, 4'd0, 4'd0, 4'd0, 8'h00);
        @(negedge clk);
        chk("rst_ft", {7'b0, futransmitout}, 8'h00);
        chk("rst_fco", {7'b0, fuclaimedout}, 8'h00);
        chk("rst_cto", {7'b0, camtransmitout}, 8'h00);
        chk("rst_op", operandout, 8'h00);
        chk("rst_val", depvalsout[0] | depvalsout[1], 8'h00);
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].cam, tbl[i].fc, tbl[i].op, tbl[i].wb, tbl[i].fl, tbl[i].rob,
                  tbl[i].d1, tbl[i].d0, tbl[i].dins, tbl[i].dval);
            @(negedge clk);
            chk($sformatf("t%0d_ft", i), {7'b0, futransmitout}, {7'b0, tbl[i].ft});
            chk($sformatf("t%0d_fco", i), {7'b0, fuclaimedout}, {7'b0, tbl[i].fco});
            chk($sformatf("t%0d_cto", i), {7'b0, camtransmitout}, {7'b0, tbl[i].cto});
            chk($sformatf("t%0d_op", i), operandout, tbl[i].eop);
            chk($sformatf("t%0d_wb", i), wbsout, tbl[i].ewb);
            chk($sformatf("t%0d_fl", i), flagout, tbl[i].efl);
            chk($sformatf("t%0d_rob", i), robidout, tbl[i].erob);
            if (tbl[i].vm[1]) chk($sformatf("t%0d_v1", i), depvalsout[1], tbl[i].ev1);
            if (tbl[i].vm[0]) chk($sformatf("t%0d_v0", i), depvalsout[0], tbl[i].ev0);
            @(posedge clk); #1;
        end

        // reset asserted mid-cycle while the slot is offering an issue
        drive(1, 0, 8'h77, 8'h66, 8'h55, 8'h44, 4'd0, 4'd0, 4'd0, 8'h00);
        @(posedge clk); #1;
        drive(0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0, 4'd0, 4'd0, 8'h00);
        #1 chk("mr_pre_ft", {7'b0, futransmitout}, 8'h01);
        chk("mr_pre_op", operandout, 8'h77);
        #1 rst = 1;
        #1 chk("mr_ft", {7'b0, futransmitout}, 8'h00);
        chk("mr_fco", {7'b0, fuclaimedout}, 8'h00);
        chk("mr_op", operandout, 8'h00);
        chk("mr_rob", robidout, 8'h00);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("mr_post_ft", {7'b0, futransmitout}, 8'h00);
        @(posedge clk); #1;

        model_reset();
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                  8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                  4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 8'($urandom));
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
